// File: rtl/exu_sched.sv
// -----------------------------------------------------------------------------
// exu_sched : issue/completion controller for the execute stage.
//
// Takes one instruction at a time from idu. Single-cycle ops are retired
// straight from the combinational ALU/branch path. MDU-class ops are handed to
// the iterative multiply/divide unit, and the controller waits for its result.
// Every result lands in a one-entry output slot that lsu drains over
// valid/ready. A flush discards in-flight work. An MDU op that is already
// running cannot be aborted, so its late result is swallowed in MDU_DRAIN.
//
// Ports:
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   e_valid_i / e_ready_o     instruction handshake with idu
//   is_mdu_i                  instruction needs the MDU
//   alu_res_i/npc_i/cnd_i     combinational ALU result, next-pc, condition
//   mdu_start_o               one-cycle dispatch pulse to the MDU
//   mdu_done_i / mdu_res_i    MDU completion pulse and result
//   flush_i                   discard all in-flight work
//   e_valid_o / e_ready_i     output slot handshake with lsu
//   res_o, npc_o, cnd_o       registered result, next-pc, condition
//   busy_o                    controller not in IDLE
//   stall_cnt_o               saturating count of idu stall cycles
// -----------------------------------------------------------------------------
module exu_sched #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             e_valid_i,
  output logic             e_ready_o,
  input  logic             is_mdu_i,
  input  logic [XLEN-1:0]  alu_res_i,
  input  logic [PC_W-1:0]  alu_npc_i,
  input  logic             alu_cnd_i,
  output logic             mdu_start_o,
  input  logic             mdu_done_i,
  input  logic [XLEN-1:0]  mdu_res_i,
  input  logic             flush_i,
  output logic             e_valid_o,
  input  logic             e_ready_i,
  output logic [XLEN-1:0]  res_o,
  output logic [PC_W-1:0]  npc_o,
  output logic             cnd_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_MDU_WAIT  = 2'd1;
  localparam logic [1:0] S_MDU_DRAIN = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q,     state_d;
  logic             out_vld_q,   out_vld_d;
  logic [XLEN-1:0]  res_q,       res_d;
  logic [PC_W-1:0]  npc_q,       npc_d;
  logic             cnd_q,       cnd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;

  // A new op may enter only when idle, not flushing, and the slot is either
  // empty or being drained this cycle. Gating with rst_n_i keeps ready low
  // for the whole time reset is held, not just after the first edge.
  assign e_ready_o   = rst_n_i && (state_q == S_IDLE) && !flush_i &&
                       (!out_vld_q || e_ready_i);
  assign accept      = e_valid_i && e_ready_o;
  assign mdu_start_o = accept && is_mdu_i;

  assign e_valid_o   = out_vld_q;
  assign res_o       = res_q;
  assign npc_o       = npc_q;
  assign cnd_o       = cnd_q;
  assign busy_o      = (state_q != S_IDLE);
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    out_vld_d   = out_vld_q;
    res_d       = res_q;
    npc_d       = npc_q;
    cnd_d       = cnd_q;
    stall_cnt_d = stall_cnt_q;

    if (e_valid_i && !e_ready_o && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end

    if (flush_i) begin
      // Flush wins over everything. A running MDU op cannot be cancelled, so
      // unless its result arrives right now we wait it out in MDU_DRAIN.
      out_vld_d = 1'b0;
      case (state_q)
        S_MDU_WAIT:  state_d = mdu_done_i ? S_IDLE : S_MDU_DRAIN;
        S_MDU_DRAIN: if (mdu_done_i) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end else begin
      // The drain clears the slot. An ALU capture below can set it again.
      if (out_vld_q && e_ready_i) begin
        out_vld_d = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            npc_d = alu_npc_i;
            cnd_d = alu_cnd_i;
            if (is_mdu_i) begin
              state_d = S_MDU_WAIT;
            end else begin
              res_d     = alu_res_i;
              out_vld_d = 1'b1;
            end
          end
        end
        S_MDU_WAIT: begin
          if (mdu_done_i) begin
            res_d     = mdu_res_i;
            out_vld_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_MDU_DRAIN: begin
          if (mdu_done_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, with no ordering race between blocks.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      out_vld_q   <= 1'b0;
      res_q       <= '0;
      npc_q       <= '0;
      cnd_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_vld_q   <= out_vld_d;
      res_q       <= res_d;
      npc_q       <= npc_d;
      cnd_q       <= cnd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_exu_sched.sv
// -----------------------------------------------------------------------------
// tb_exu_sched : scoreboard bench for exu_sched.
//
// The driver applies one input vector per cycle and advances a transaction-
// level model. The model tracks whether the output slot holds something and
// what the MDU is doing: nothing, running, or running but already flushed.
// Each result the model expects to be delivered is queued. A separate monitor
// pops the queue whenever lsu takes the slot and compares the payload.
// -----------------------------------------------------------------------------
module tb_exu_sched;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        e_valid_i, is_mdu_i, alu_cnd_i, mdu_done_i, flush_i, e_ready_i;
  logic [31:0] alu_res_i, alu_npc_i, mdu_res_i;
  logic        e_ready_o, mdu_start_o, e_valid_o, cnd_o, busy_o;
  logic [31:0] res_o, npc_o, stall_cnt_o;

  exu_sched #(.XLEN(32), .PC_W(32), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .e_valid_i(e_valid_i), .e_ready_o(e_ready_o), .is_mdu_i(is_mdu_i),
    .alu_res_i(alu_res_i), .alu_npc_i(alu_npc_i), .alu_cnd_i(alu_cnd_i),
    .mdu_start_o(mdu_start_o), .mdu_done_i(mdu_done_i), .mdu_res_i(mdu_res_i),
    .flush_i(flush_i), .e_valid_o(e_valid_o), .e_ready_i(e_ready_i),
    .res_o(res_o), .npc_o(npc_o), .cnd_o(cnd_o), .busy_o(busy_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic [31:0] npc;
    logic        cnd;
  } exp_t;

  typedef enum {P_NONE, P_RUN, P_KILLED} mdu_phase_e;

  exp_t        exp_q[$];
  mdu_phase_e  m_phase;
  bit          m_slot_full;
  logic [31:0] m_stall;
  logic [31:0] m_pend_npc;
  logic        m_pend_cnd;
  int unsigned m_cd;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_phase     = P_NONE;
    m_slot_full = 1'b0;
    m_stall     = '0;
    m_cd        = 0;
  endtask

  // Apply one vector, check the DUT against the model, update the model,
  // then advance one clock. Entered and left shortly after a rising edge.
  task automatic step(input logic ev, input logic mdu, input logic [31:0] res,
                      input logic [31:0] npc, input logic cnd, input logic rdy,
                      input logic fl, input logic dn, input logic [31:0] mres);
    bit   exp_rdy, acc;
    exp_t e;
    e_valid_i = ev;  is_mdu_i = mdu; alu_res_i = res; alu_npc_i = npc;
    alu_cnd_i = cnd; e_ready_i = rdy; flush_i  = fl;  mdu_done_i = dn;
    mdu_res_i = mres;
    #1;
    exp_rdy = (m_phase == P_NONE) && !fl && (!m_slot_full || rdy);
    acc     = ev && exp_rdy;
    check("e_ready_o",   64'(e_ready_o),   64'(exp_rdy));
    check("mdu_start_o", 64'(mdu_start_o), 64'(acc && mdu));
    check("e_valid_o",   64'(e_valid_o),   64'(m_slot_full));
    check("busy_o",      64'(busy_o),      64'(m_phase != P_NONE));
    check("stall_cnt_o", 64'(stall_cnt_o), 64'(m_stall));

    if (ev && !exp_rdy && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;

    if (fl) begin
      // An undelivered slot entry is thrown away unless lsu takes it now.
      if (m_slot_full && !rdy && exp_q.size() > 0) void'(exp_q.pop_back());
      m_slot_full = 1'b0;
      if (m_phase == P_RUN)              m_phase = dn ? P_NONE : P_KILLED;
      else if (m_phase == P_KILLED && dn) m_phase = P_NONE;
    end else begin
      if (m_slot_full && rdy) m_slot_full = 1'b0;
      if (acc) begin
        if (mdu) begin
          m_phase    = P_RUN;
          m_pend_npc = npc;
          m_pend_cnd = cnd;
          m_cd       = $urandom_range(0, 5);
        end else begin
          e.res = res; e.npc = npc; e.cnd = cnd;
          exp_q.push_back(e);
          m_slot_full = 1'b1;
        end
      end else if (m_phase == P_RUN && dn) begin
        e.res = mres; e.npc = m_pend_npc; e.cnd = m_pend_cnd;
        exp_q.push_back(e);
        m_slot_full = 1'b1;
        m_phase     = P_NONE;
      end else if (m_phase == P_KILLED && dn) begin
        m_phase = P_NONE;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rdy, 1'b0, 1'b0, 32'h0);
  endtask

  // Random vector. The MDU answers after a random delay; occasionally a
  // spurious done shows up while nothing is running.
  task automatic rand_step(input bit quiet);
    logic ev, mdu, cnd, rdy, fl, dn;
    logic [31:0] r, n, mr;
    ev  = !quiet && ($urandom_range(0, 99) < 70);
    mdu = ($urandom_range(0, 99) < 25);
    r   = $urandom;
    n   = $urandom;
    mr  = $urandom;
    cnd = 1'($urandom_range(0, 1));
    rdy = quiet || ($urandom_range(0, 99) < 70);
    fl  = !quiet && ($urandom_range(0, 99) < 4);
    if (m_phase != P_NONE) begin
      dn = (m_cd == 0);
      if (m_cd != 0) m_cd--;
    end else begin
      dn = !quiet && ($urandom_range(0, 99) < 3);
    end
    step(ev, mdu, r, n, cnd, rdy, fl, dn, mr);
  endtask

  // Monitor: lsu takes the slot on valid && ready, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && e_valid_o && e_ready_i) begin
        if (exp_q.size() == 0) begin
          check("output_without_expectation", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("res_o", 64'(res_o), 64'(e.res));
          check("npc_o", 64'(npc_o), 64'(e.npc));
          check("cnd_o", 64'(cnd_o), 64'(e.cnd));
        end
      end
    end
  end

  initial begin
    model_reset();
    rst_n_i = 1'b0;
    e_valid_i = 1'b1; is_mdu_i = 1'b1; alu_res_i = '0; alu_npc_i = '0;
    alu_cnd_i = 1'b0; mdu_done_i = 1'b0; mdu_res_i = '0; flush_i = 1'b0;
    e_ready_i = 1'b1;
    #12;
    check("rst_e_ready_o",   64'(e_ready_o),   64'd0);
    check("rst_mdu_start_o", 64'(mdu_start_o), 64'd0);
    check("rst_e_valid_o",   64'(e_valid_o),   64'd0);
    check("rst_busy_o",      64'(busy_o),      64'd0);
    check("rst_stall_cnt_o", 64'(stall_cnt_o), 64'd0);
    check("rst_res_o",       64'(res_o),       64'd0);
    e_valid_i = 1'b0;
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // ALU streaming at full throughput.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
    check("stream_stall_cnt", 64'(stall_cnt_o), 64'd0);

    // Backpressure: the slot holds while lsu stalls, then drains and refills.
    step(1'b1, 1'b0, 32'hA5, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hB6, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("bp_res_hold",  64'(res_o),       64'hA5);
    check("bp_stall_cnt", 64'(stall_cnt_o), 64'd3);
    step(1'b1, 1'b0, 32'hC7, 32'h208, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);

    // MDU op, done five cycles after start.
    step(1'b1, 1'b1, 32'h0, 32'h8000_0004, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    check("mdu_res_o",  64'(res_o),  64'h1234_5678);
    check("mdu_npc_o",  64'(npc_o),  64'h8000_0004);
    check("mdu_busy_o", 64'(busy_o), 64'd0);
    idle(1'b1);

    // Flush while the MDU runs: its late result must vanish.
    step(1'b1, 1'b1, 32'h0, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("drain_busy_o", 64'(busy_o), 64'd1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h55, 32'h304, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD);
    check("drain_no_valid", 64'(e_valid_o), 64'd0);
    step(1'b1, 1'b0, 32'h77, 32'h308, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);

    // Flush and done in the same cycle, then a spurious done in IDLE.
    step(1'b1, 1'b1, 32'h0, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hBEEF);
    check("coinc_busy_o", 64'(busy_o), 64'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFACE);
    check("spurious_valid", 64'(e_valid_o), 64'd0);
    check("spurious_busy",  64'(busy_o),    64'd0);

    // Async reset in the middle of an MDU op.
    step(1'b1, 1'b1, 32'h0, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(1'b1);
    e_valid_i = 1'b1; is_mdu_i = 1'b1;
    #2 rst_n_i = 1'b0;
    #1;
    check("amid_e_ready_o",   64'(e_ready_o),   64'd0);
    check("amid_mdu_start_o", 64'(mdu_start_o), 64'd0);
    check("amid_e_valid_o",   64'(e_valid_o),   64'd0);
    check("amid_busy_o",      64'(busy_o),      64'd0);
    check("amid_npc_o",       64'(npc_o),       64'd0);
    check("amid_cnd_o",       64'(cnd_o),       64'd0);
    check("amid_stall_cnt_o", 64'(stall_cnt_o), 64'd0);
    model_reset();
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // Stall counter saturation from a preloaded value.
    step(1'b1, 1'b0, 32'h11, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h22, 32'h604, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("sat_stall_cnt", 64'(stall_cnt_o), 64'hFFFF_FFFF);
    idle(1'b1);

    // Randomized traffic, then a quiet tail so everything drains.
    for (int i = 0; i < 2000; i++) rand_step(1'b0);
    for (int i = 0; i < 12; i++) rand_step(1'b1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
